// File: rtl/cv32e40p_instr_aligner.sv
// cv32e40p_instr_aligner: splits word-aligned fetch words into RVC/32-bit instructions with PC tracking; optional CV32E40P_ALIGNER_HWLP_EN adds hardware-loop redirects
module cv32e40p_instr_aligner #(
    parameter logic [31:0] BOOT_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_valid_i,
    output logic        fetch_ready_o,
    input  logic [31:0] fetch_rdata_i,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    output logic [31:0] instr_aligned_o,
    output logic        instr_is_rvc_o,
    output logic [31:0] pc_o,
`ifdef CV32E40P_ALIGNER_HWLP_EN
    input  logic        hwlp_jump_i,
    input  logic [31:0] hwlp_target_i,
`endif
    input  logic        branch_i,
    input  logic [31:0] branch_addr_i
);
    typedef enum logic [1:0] {ALIGNED, MISALIGNED, BRANCH_MISALIGNED} state_e;
    state_e      state_q, state_d, nxt_state;
    logic [31:0] pc_q, pc_d, pc_inc;
    logic [15:0] res_q, res_d, nxt_res;
    logic        valid, uses_word, bubble, xfer, advance;
    // decode the current half-word pair, then commit on transfer, bubble, loop jump or branch
    always_comb begin
        valid           = fetch_valid_i;
        uses_word       = 1'b1;
        bubble          = 1'b0;
        nxt_state       = state_q;
        nxt_res         = res_q;
        pc_inc          = 32'd4;
        instr_aligned_o = fetch_rdata_i;
        instr_is_rvc_o  = 1'b0;
        case (state_q)
            MISALIGNED: begin
                if (res_q[1:0] != 2'b11) begin
                    valid           = 1'b1;
                    uses_word       = 1'b0;
                    instr_aligned_o = {16'b0, res_q};
                    instr_is_rvc_o  = 1'b1;
                    pc_inc          = 32'd2;
                    nxt_state       = ALIGNED;
                end else begin
                    instr_aligned_o = {fetch_rdata_i[15:0], res_q};
                    nxt_res         = fetch_rdata_i[31:16];
                end
            end
            BRANCH_MISALIGNED: begin
                instr_aligned_o = {16'b0, fetch_rdata_i[31:16]};
                instr_is_rvc_o  = 1'b1;
                pc_inc          = 32'd2;
                nxt_state       = ALIGNED;
                if (fetch_rdata_i[17:16] == 2'b11) begin
                    valid     = 1'b0;
                    bubble    = 1'b1;
                    pc_inc    = 32'd0;
                    nxt_state = MISALIGNED;
                    nxt_res   = fetch_rdata_i[31:16];
                end
            end
            default: begin
                if (fetch_rdata_i[1:0] != 2'b11) begin
                    instr_aligned_o = {16'b0, fetch_rdata_i[15:0]};
                    instr_is_rvc_o  = 1'b1;
                    pc_inc          = 32'd2;
                    nxt_state       = MISALIGNED;
                    nxt_res         = fetch_rdata_i[31:16];
                end
            end
        endcase
        instr_valid_o = valid && !branch_i && !rst;
        xfer          = instr_valid_o && instr_ready_i;
        advance       = xfer || (bubble && fetch_valid_i && !branch_i && !rst);
        fetch_ready_o = uses_word && advance;
        pc_o          = pc_q;
        state_d       = advance ? nxt_state : state_q;
        pc_d          = advance ? pc_q + pc_inc : pc_q;
        res_d         = advance ? nxt_res : res_q;
`ifdef CV32E40P_ALIGNER_HWLP_EN
        if (xfer && hwlp_jump_i) begin
            pc_d    = hwlp_target_i;
            state_d = hwlp_target_i[1] ? BRANCH_MISALIGNED : ALIGNED;
            res_d   = 16'b0;
        end
`endif
        if (branch_i) begin
            pc_d    = branch_addr_i;
            state_d = branch_addr_i[1] ? BRANCH_MISALIGNED : ALIGNED;
            res_d   = 16'b0;
        end
    end
    // state, residue and PC registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ALIGNED;
            pc_q    <= BOOT_ADDR;
            res_q   <= 16'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            res_q   <= res_d;
        end
    end
endmodule

// File: tb/tb_cv32e40p_instr_aligner.sv
// tb_cv32e40p_instr_aligner: directed stimulus with a scoreboard-checked instruction stream
module tb_cv32e40p_instr_aligner;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fetch_valid_i = 1'b0;
    logic        fetch_ready_o;
    logic [31:0] fetch_rdata_i = 32'b0;
    logic        instr_valid_o;
    logic        instr_ready_i = 1'b1;
    logic [31:0] instr_aligned_o;
    logic        instr_is_rvc_o;
    logic [31:0] pc_o;
    logic        branch_i = 1'b0;
    logic [31:0] branch_addr_i = 32'b0;

    typedef struct packed {
        logic [31:0] instr;
        logic        rvc;
        logic [31:0] pc;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] fifo[$];
    logic        pop_seen = 1'b0;
    int          tests = 0;
    int          fails = 0;

    cv32e40p_instr_aligner #(.BOOT_ADDR(32'h0)) dut (
        .clk(clk), .rst(rst),
        .fetch_valid_i(fetch_valid_i), .fetch_ready_o(fetch_ready_o), .fetch_rdata_i(fetch_rdata_i),
        .instr_valid_o(instr_valid_o), .instr_ready_i(instr_ready_i),
        .instr_aligned_o(instr_aligned_o), .instr_is_rvc_o(instr_is_rvc_o), .pc_o(pc_o),
        .branch_i(branch_i), .branch_addr_i(branch_addr_i)
    );

    always #5 clk = ~clk;

    // monitor: compare every transferred instruction against the scoreboard and note FIFO pops
    always @(negedge clk) begin
        pop_seen = fetch_valid_i && fetch_ready_o;
        if (fetch_ready_o && !fetch_valid_i) begin
            tests++;
            fails++;
            $display("FAIL ready_without_valid at %0t", $time);
        end
        if (!rst && instr_valid_o && instr_ready_i) begin
            tests++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL unexpected_instr got %h pc %h, required none", instr_aligned_o, pc_o);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (instr_aligned_o !== e.instr || instr_is_rvc_o !== e.rvc || pc_o !== e.pc) begin
                    fails++;
                    $display("FAIL stream got instr %h rvc %b pc %h, required instr %h rvc %b pc %h",
                             instr_aligned_o, instr_is_rvc_o, pc_o, e.instr, e.rvc, e.pc);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s got %h, required %h", name, act, exp);
        end
    endtask

    task automatic refresh();
        fetch_valid_i = fifo.size() != 0;
        fetch_rdata_i = fifo.size() != 0 ? fifo[0] : 32'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (pop_seen) void'(fifo.pop_front());
        pop_seen = 1'b0;
        refresh();
    endtask

    task automatic push(input logic [31:0] w);
        fifo.push_back(w);
        refresh();
    endtask

    task automatic expect_instr(input logic [31:0] i, input logic r, input logic [31:0] p);
        sb.push_back('{instr: i, rvc: r, pc: p});
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (sb.size() != 0 && n < 50) begin
            step();
            n++;
        end
        chk({name, "_drained"}, sb.size(), 0);
    endtask

    task automatic branch_to(input logic [31:0] a);
        branch_i = 1'b1;
        branch_addr_i = a;
        #1;
        chk("branch_valid_low", {31'b0, instr_valid_o}, 0);
        chk("branch_ready_low", {31'b0, fetch_ready_o}, 0);
        step();
        branch_i = 1'b0;
        #1;
        chk("branch_pc", pc_o, a);
    endtask

    initial begin
        push(32'h0041_0113);
        step();
        #1;
        chk("rst_valid_low", {31'b0, instr_valid_o}, 0);
        chk("rst_ready_low", {31'b0, fetch_ready_o}, 0);
        step();
        void'(fifo.pop_front());
        refresh();
        rst = 1'b0;
        #1;
        chk("reset_pc", pc_o, 32'h0);
        chk("reset_empty_valid", {31'b0, instr_valid_o}, 0);

        expect_instr(32'h0041_0113, 1'b0, 32'h0);
        expect_instr(32'h0000_4501, 1'b1, 32'h4);
        expect_instr(32'h0000_0001, 1'b1, 32'h6);
        push(32'h0041_0113);
        push(32'h0001_4501);
        drain("aligned_stream");
        #1;
        chk("aligned_end_pc", pc_o, 32'h8);

        branch_to(32'h0);
        expect_instr(32'h0000_4501, 1'b1, 32'h0);
        expect_instr(32'h0000_0513, 1'b0, 32'h2);
        expect_instr(32'h0000_1234, 1'b1, 32'h6);
        push(32'h0513_4501);
        push(32'h1234_0000);
        drain("straddle");
        #1;
        chk("straddle_end_pc", pc_o, 32'h8);

        expect_instr(32'h0000_8082, 1'b1, 32'h102);
        push(32'h8082_1111);
        branch_to(32'h102);
        drain("branch_misaligned");
        #1;
        chk("bm_end_pc", pc_o, 32'h104);
        chk("bm_fifo_empty_valid", {31'b0, instr_valid_o}, 0);

        instr_ready_i = 1'b0;
        push(32'h0041_0113);
        push(32'h0001_4501);
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("stall_pc", pc_o, 32'h104);
            chk("stall_instr", instr_aligned_o, 32'h0041_0113);
            chk("stall_valid", {31'b0, instr_valid_o}, 1);
            chk("stall_fetch_ready", {31'b0, fetch_ready_o}, 0);
            step();
        end
        expect_instr(32'h0041_0113, 1'b0, 32'h104);
        expect_instr(32'h0000_4501, 1'b1, 32'h108);
        expect_instr(32'h0000_0001, 1'b1, 32'h10a);
        instr_ready_i = 1'b1;
        drain("after_stall");

        branch_to(32'h202);
        expect_instr(32'h0000_0513, 1'b0, 32'h202);
        push(32'h0513_0000);
        push(32'hABCD_0000);
        drain("bubble_straddle");
        instr_ready_i = 1'b0;
        #1;
        chk("res_valid", {31'b0, instr_valid_o}, 1);
        chk("res_instr", instr_aligned_o, 32'h0000_ABCD);
        chk("res_pc", pc_o, 32'h206);
        chk("res_fetch_ready", {31'b0, fetch_ready_o}, 0);
        rst = 1'b1;
        #1;
        chk("rst_mis_valid", {31'b0, instr_valid_o}, 0);
        step();
        #1;
        chk("rst_mis_valid2", {31'b0, instr_valid_o}, 0);
        chk("rst_mis_ready", {31'b0, fetch_ready_o}, 0);
        rst = 1'b0;
        #1;
        chk("rst_mis_pc", pc_o, 32'h0);
        chk("rst_mis_state_aligned", {31'b0, instr_valid_o}, 0);

        instr_ready_i = 1'b1;
        branch_to(32'hFFFF_FFFC);
        expect_instr(32'h0000_0001, 1'b1, 32'hFFFF_FFFC);
        expect_instr(32'h0000_0001, 1'b1, 32'hFFFF_FFFE);
        push(32'h0001_0001);
        drain("wrap");
        #1;
        chk("wrap_pc", pc_o, 32'h0);
        chk("fifo_consumed", fifo.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/cv32e40p_instr_aligner.md
Name: cv32e40p_instr_aligner

Overview:
Sits directly downstream of the prefetch buffer. It consumes 32-bit word-aligned fetch words through a valid/ready handshake and presents one complete instruction per handshake to the ID stage. The instruction is either a 16-bit RVC instruction or a 32-bit instruction, and a 32-bit instruction may straddle two fetch words. The block tracks the instruction PC and redirects on a taken branch.

Parameters:
BOOT_ADDR, 32'h0000_0000, PC value loaded at reset.

Ports:
clk  in  1  clock; all state updates on rising edge.
rst  in  1  synchronous reset, active-high.
fetch_valid_i  in  1  fetch word available from the prefetch buffer.
fetch_ready_o  out  1  word consumed this cycle (prefetch buffer FIFO pop).
fetch_rdata_i  in  32  fetch word; its address is always word-aligned.
instr_valid_o  out  1  aligned instruction valid.
instr_ready_i  in  1  ID stage accepts the instruction.
instr_aligned_o  out  32  instruction; RVC is zero-extended in [15:0].
instr_is_rvc_o  out  1  instruction is 16-bit (bits[1:0] != 2'b11).
pc_o  out  32  PC of instr_aligned_o.
branch_i  in  1  taken branch / redirect, one-cycle pulse.
branch_addr_i  in  32  target; bit0 is always 0.

Behaviour:
- Interface: single clock clk; reset rst is synchronous, active-high.
- State register: state in {ALIGNED, MISALIGNED, BRANCH_MISALIGNED}, plus the 16-bit residue register res_q and the 32-bit pc_q.
- Reset (rst=1 at edge):
  - state=ALIGNED, pc_q=BOOT_ADDR, res_q=0.
  - While rst=1, instr_valid_o=0 and fetch_ready_o=0, regardless of inputs.
- Outputs are combinational from the state and the fetch inputs, giving zero-latency fall-through.
- Handshakes:
  - An instruction transfers when instr_valid_o && instr_ready_i.
  - A word is consumed when fetch_valid_i && fetch_ready_o.
  - fetch_ready_o is never asserted without fetch_valid_i.
- ALIGNED (pc_q[1]=0), needs fetch_valid_i:
  - If w[1:0]==11: output w, rvc=0. On transfer: consume the word, pc+=4, stay in ALIGNED.
  - Otherwise: output {16'b0, w[15:0]}, rvc=1. On transfer: consume the word, res_q<=w[31:16], pc+=2, go to MISALIGNED.
- MISALIGNED (pc_q[1]=1, res_q holds the low half):
  - If res_q[1:0]!=11: output the RVC instruction from res_q with instr_valid_o=1 independent of fetch_valid_i, and fetch_ready_o=0. On transfer: pc+=2, go to ALIGNED.
  - Otherwise the 32-bit instruction straddles words: needs fetch_valid_i, output {w[15:0], res_q}. On transfer: consume the word, res_q<=w[31:16], pc+=4, stay in MISALIGNED.
- BRANCH_MISALIGNED (target bit1=1), needs fetch_valid_i; the lower half of the word is discarded:
  - If w[17:16]!=11: output {16'b0, w[31:16]}, rvc=1. On transfer: consume the word, pc+=2, go to ALIGNED.
  - Otherwise: no output (instr_valid_o=0). Consume the word, res_q<=w[31:16], go to MISALIGNED. This costs one bubble.
- branch_i:
  - In the same cycle: instr_valid_o=0 and fetch_ready_o=0, so no transfer occurs and no FIFO pop happens.
  - Next state: pc_q<=branch_addr_i; state<=branch_addr_i[1] ? BRANCH_MISALIGNED : ALIGNED; res_q is discarded.
  - branch_i has priority over any pending transfer.
- Stalls: with instr_ready_i=0, no state changes occur; outputs stay stable while the inputs are stable.
- Arithmetic: PC wraps modulo 2^32; 32'hFFFF_FFFE+2 = 0.
- Empty FIFO in a state that needs a word: instr_valid_o=0.

Optional Feature:
Macro CV32E40P_ALIGNER_HWLP_EN adds two ports: hwlp_jump_i (in, 1) and hwlp_target_i (in, 32).
- hwlp_jump_i is sampled only on an instruction transfer.
- On that transfer, the next state is computed as for a branch to hwlp_target_i: pc_q<=target, state by target[1], residue discarded.
- The word being consumed in that cycle is still popped.
- branch_i has priority over hwlp_jump_i.
- Without the macro, the ports are absent and no hwlp logic is present.

Test Plan:
- Reset, then ALIGNED with words 32'h0041_0113, 32'h0001_4501 streamed and instr_ready_i=1: outputs 32'h0041_0113 @pc 0, then 32'h0000_4501 rvc @pc 4, then 32'h0000_0001 rvc @pc 6.
- MISALIGNED straddle: after RVC at pc 0 from word 32'h0513_4501, next word 32'h1234_0000: outputs {16'h0000, 16'h0513} = 32'h0000_0513 @pc 2, res_q=16'h1234, pc=6.
- Branch to 32'h0000_0102 with word 32'h8082_1111: discards 16'h1111, outputs 32'h0000_8082 rvc @pc 0x102, one word consumed, next state ALIGNED at pc 0x104.
- branch_i asserted while fetch_valid_i=1 and instr_ready_i=1: instr_valid_o=0 and fetch_ready_o=0 that cycle, and the next pc equals branch_addr_i.
- Back-pressure: instr_ready_i=0 for 5 cycles mid-stream: pc_o, instr_aligned_o and state are unchanged, fetch_ready_o=0 throughout, and no word is lost.
- rst asserted while in MISALIGNED with res_q=16'hABCD: next cycle state=ALIGNED, pc=BOOT_ADDR, outputs low during reset.
